// File: rtl/simple_processor_pkg.sv
// Shared processor types: data width, memory function codes and LSU state encoding.
// TIMEOUT_CYCLES only takes effect when DMEM_LSU_TIMEOUT_EN is defined.
package simple_processor_pkg;

  localparam int DATA_WIDTH           = 32;
  localparam int DMEM_ADDR_ALIGN_BITS = 2;
  localparam int TIMEOUT_CYCLES       = 16;

  // Codes 2'b00 and 2'b11 are deliberately left unassigned so a corrupt
  // function field is detectable rather than aliasing to a real operation.
  typedef enum logic [1:0] {
    LOAD  = 2'b01,
    STORE = 2'b10
  } func_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    RESP,
    ERR_RSP
  } lsu_state_t;

  function automatic logic is_mem_func(func_t f);
    return (f == LOAD) || (f == STORE);
  endfunction

  function automatic logic is_aligned(logic [DMEM_ADDR_ALIGN_BITS-1:0] low_bits);
    return low_bits == '0;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Upstream request/response and data-memory bus signals of the load/store unit.
// The slave modport is the LSU's view; master is the surrounding pipeline plus memory.
interface dmem_lsu_if;
  import simple_processor_pkg::*;

  logic                  req_valid_i;
  logic                  req_ready_o;
  func_t                 func_i;
  logic [DATA_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;
  logic                  busy_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, func_i, addr_i, wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rdata_o, err_o, busy_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, func_i, addr_i, wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rdata_o, err_o, busy_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/dmem_lsu_timer.sv
// Access timeout counter for the LSU, only instantiated when DMEM_LSU_TIMEOUT_EN is defined.
// Counts cycles spent waiting on the memory and flags the last allowed cycle.
module dmem_lsu_timer #(
  parameter int CYCLES = 16
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic start_i,
  input  logic active_i,
  output logic expire_o
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at the last value so a grant that just beat expiry cannot
  // reopen a fresh window for the read-data wait.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (active_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = active_i && (cnt_q == LAST);

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the ALU memory stage and the data memory (req/gnt/rvalid bus).
// Optional access timeout is enabled by defining DMEM_LSU_TIMEOUT_EN.
module dmem_lsu
  import simple_processor_pkg::*;
(
  input  logic      clk_i,
  input  logic      arst_ni,
  dmem_lsu_if.slave bus
);

  lsu_state_t            state_q, state_d;
  func_t                 func_q, func_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  accept;
  logic                  req_ok;
  logic                  timeout;
  logic                  is_store;

  assign accept   = (state_q == IDLE) && bus.req_valid_i;
  assign req_ok   = is_mem_func(bus.func_i) &&
                    is_aligned(bus.addr_i[DMEM_ADDR_ALIGN_BITS-1:0]);
  assign is_store = (func_q == STORE);

`ifdef DMEM_LSU_TIMEOUT_EN
  dmem_lsu_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .arst_ni  (arst_ni),
    .start_i  (accept && req_ok),
    .active_i ((state_q == REQ) || (state_q == WAIT_RSP)),
    .expire_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A grant or rvalid takes priority over an expiring timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req_ok ? REQ : ERR_RSP;
        end
      end
      REQ: begin
        if (bus.mem_gnt_i) begin
          state_d = is_store ? RESP : WAIT_RSP;
        end else if (timeout) begin
          state_d = ERR_RSP;
        end
      end
      WAIT_RSP: begin
        if (bus.mem_rvalid_i) begin
          state_d = RESP;
        end else if (timeout) begin
          state_d = ERR_RSP;
        end
      end
      RESP:    state_d = IDLE;
      ERR_RSP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured only at the accept handshake.
  always_comb begin
    func_d  = func_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept) begin
      func_d  = bus.func_i;
      addr_d  = bus.addr_i;
      wdata_d = bus.wdata_i;
    end
    if ((state_q == WAIT_RSP) && bus.mem_rvalid_i) begin
      rdata_d = bus.mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      func_q  <= func_t'('0);
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      func_q  <= func_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode from state only, so an asynchronous reset clears them immediately.
  // addr_q is already word-aligned whenever REQ is reached.
  always_comb begin
    bus.req_ready_o = 1'b0;
    bus.busy_o      = 1'b1;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.rsp_valid_o = 1'b0;
    bus.err_o       = 1'b0;
    bus.rdata_o     = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        bus.busy_o      = 1'b0;
      end
      REQ: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = is_store;
        bus.mem_addr_o  = addr_q;
        bus.mem_wdata_o = is_store ? wdata_q : '0;
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rdata_o     = is_store ? '0 : rdata_q;
      end
      ERR_RSP: begin
        bus.rsp_valid_o = 1'b1;
        bus.err_o       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed latency/boundary vectors, a randomised
// memory-delay run, and (with DMEM_LSU_TIMEOUT_EN) the timeout boundaries.
module tb_dmem_lsu;
  import simple_processor_pkg::*;

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_t;

  logic clk   = 1'b0;
  logic arstN = 1'b0;

  always #5 clk = ~clk;

  dmem_lsu_if bus ();

  dmem_lsu u_dut (
    .clk_i   (clk),
    .arst_ni (arstN),
    .bus     (bus)
  );

  int total    = 0;
  int bad      = 0;
  int rspCount = 0;
  int gntDelay = 0;
  int rvDelay  = 0;
  bit expectTimeout = 1'b0;

  rsp_t        expQ[$];
  logic [31:0] refMem[logic [31:0]];
  logic [31:0] memArr[logic [31:0]];

  function automatic logic [31:0] memInit(logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one request from posedge+1, waits (bounded) for the accept handshake,
  // records the expected response and returns at posedge+1 of the following cycle.
  task automatic applyStimulus(input func_t f, input logic [31:0] a, input logic [31:0] w,
                               input bit hold, output int waited);
    rsp_t e;
    bus.req_valid_i = 1'b1;
    bus.func_i      = f;
    bus.addr_i      = a;
    bus.wdata_i     = w;
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready_o && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.req_ready_o) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_wait: got no req_ready_o expected accept within 300 cycles");
    end else begin
      e.err   = (a[1:0] != 2'b00) || !((f == LOAD) || (f == STORE)) || expectTimeout;
      e.rdata = '0;
      if (!e.err) begin
        if (f == STORE) refMem[a] = w;
        else e.rdata = refMem.exists(a) ? refMem[a] : memInit(a);
      end
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid_i = 1'b0;
  endtask

  // Memory model: grants after gntDelay REQ cycles, returns read data rvDelay cycles later.
  initial begin : memResponder
    bit          reqSeen;
    bit          rdPending;
    int          gWait;
    int          rdWait;
    logic [31:0] rdAddr;
    reqSeen   = 1'b0;
    rdPending = 1'b0;
    gWait     = 0;
    rdWait    = 0;
    rdAddr    = '0;
    memArr[32'h40]   = 32'h12345678;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = '0;
      if (rdPending) begin
        if (rdWait == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = memArr.exists(rdAddr) ? memArr[rdAddr] : memInit(rdAddr);
          rdPending = 1'b0;
        end else begin
          rdWait--;
        end
      end else if (bus.mem_req_o) begin
        if (!reqSeen) begin
          reqSeen = 1'b1;
          gWait   = gntDelay;
        end
        if (gWait == 0) begin
          bus.mem_gnt_i = 1'b1;
          reqSeen = 1'b0;
          if (bus.mem_we_o) begin
            memArr[bus.mem_addr_o] = bus.mem_wdata_o;
          end else begin
            rdPending = 1'b1;
            rdWait    = rvDelay;
            rdAddr    = bus.mem_addr_o;
          end
        end else begin
          gWait--;
        end
      end else begin
        reqSeen = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the response scoreboard and bus rules.
  initial begin : compareProc
    rsp_t        e;
    bit          prevHeld;
    logic        prevWe;
    logic [31:0] prevAddr;
    logic [31:0] prevWdata;
    prevHeld  = 1'b0;
    prevWe    = 1'b0;
    prevAddr  = '0;
    prevWdata = '0;
    forever begin
      @(negedge clk);
      if (!arstN) begin
        checkOutput("rst_ready", bus.req_ready_o, 64'd1);
        checkOutput("rst_flags", {bus.busy_o, bus.mem_req_o, bus.mem_we_o, bus.rsp_valid_o, bus.err_o}, 64'd0);
        checkOutput("rst_rdata", bus.rdata_o, 64'd0);
        prevHeld = 1'b0;
      end else begin
        checkOutput("ready_vs_busy", bus.req_ready_o, !bus.busy_o);
        if (bus.rsp_valid_o) begin
          rspCount++;
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_rsp: got rsp_valid_o=1 expected none at %0t", $time);
          end else begin
            e = expQ.pop_front();
            checkOutput("rsp_err", bus.err_o, e.err);
            checkOutput("rsp_rdata", bus.rdata_o, e.rdata);
          end
        end else begin
          checkOutput("quiet_rsp_fields", {bus.err_o, bus.rdata_o}, 64'd0);
        end
        if (bus.mem_req_o) begin
          checkOutput("mem_addr_aligned", bus.mem_addr_o[1:0], 64'd0);
          if (!bus.mem_we_o) checkOutput("load_wdata_zero", bus.mem_wdata_o, 64'd0);
          if (prevHeld) begin
            checkOutput("req_stable_we", bus.mem_we_o, prevWe);
            checkOutput("req_stable_addr_data", {bus.mem_addr_o, bus.mem_wdata_o}, {prevAddr, prevWdata});
          end
        end
        prevHeld  = bus.mem_req_o && !bus.mem_gnt_i;
        prevWe    = bus.mem_we_o;
        prevAddr  = bus.mem_addr_o;
        prevWdata = bus.mem_wdata_o;
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 1500000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int waitN;
    int waitB;
    int base;
    bus.req_valid_i = 1'b0;
    bus.func_i      = LOAD;
    bus.addr_i      = '0;
    bus.wdata_i     = '0;
    refMem[32'h40]  = 32'h12345678;

    #2;
    checkOutput("reset_ready", bus.req_ready_o, 64'd1);
    checkOutput("reset_flags", {bus.busy_o, bus.mem_req_o, bus.mem_we_o, bus.rsp_valid_o, bus.err_o}, 64'd0);
    checkOutput("reset_bus", {bus.mem_addr_o, bus.mem_wdata_o}, 64'd0);
    checkOutput("reset_rdata", bus.rdata_o, 64'd0);
    #10 arstN = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait store; inputs are scrambled after accept and must not matter.
    $display("[TB] zero-wait store");
    gntDelay = 0;
    rvDelay  = 0;
    applyStimulus(STORE, 32'h100, 32'hDEADBEEF, 1'b0, waitN);
    bus.func_i  = LOAD;
    bus.addr_i  = 32'hFFFF_FFF0;
    bus.wdata_i = 32'h0;
    @(negedge clk);
    checkOutput("st_req_we", {bus.mem_req_o, bus.mem_we_o}, 64'h3);
    checkOutput("st_addr", bus.mem_addr_o, 64'h100);
    checkOutput("st_wdata", bus.mem_wdata_o, 64'hDEADBEEF);
    checkOutput("st_busy", bus.busy_o, 64'd1);
    @(negedge clk);
    checkOutput("st_rsp_err", {bus.rsp_valid_o, bus.err_o}, 64'h2);
    checkOutput("st_rdata", bus.rdata_o, 64'd0);
    checkOutput("st_req_dropped", bus.mem_req_o, 64'd0);
    @(negedge clk);
    checkOutput("st_ready_after", bus.req_ready_o, 64'd1);
    @(posedge clk);
    #1;

    // Load with grant after 3 cycles and rvalid 2 cycles after that.
    $display("[TB] load with waits");
    gntDelay = 3;
    rvDelay  = 2;
    applyStimulus(LOAD, 32'h40, 32'h0BADF00D, 1'b0, waitN);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checkOutput("ld_busy", bus.busy_o, 64'd1);
      checkOutput("ld_mem_req", bus.mem_req_o, (c <= 4));
      if (c <= 4) begin
        checkOutput("ld_addr", bus.mem_addr_o, 64'h40);
        checkOutput("ld_we_wdata", {bus.mem_we_o, bus.mem_wdata_o}, 64'd0);
      end
      checkOutput("ld_rsp", bus.rsp_valid_o, (c == 8));
      if (c == 8) checkOutput("ld_rdata", bus.rdata_o, 64'h12345678);
    end
    @(posedge clk);
    #1;

    // Misaligned address and an illegal function code both answer in cycle 1.
    $display("[TB] error requests");
    gntDelay = 0;
    rvDelay  = 0;
    applyStimulus(LOAD, 32'h41, 32'h0, 1'b0, waitN);
    @(negedge clk);
    checkOutput("mis_rsp_err_req", {bus.rsp_valid_o, bus.err_o, bus.mem_req_o}, 64'h6);
    checkOutput("mis_rdata", bus.rdata_o, 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(func_t'(2'b11), 32'h80, 32'h1, 1'b0, waitN);
    @(negedge clk);
    checkOutput("badfn_rsp_err_req", {bus.rsp_valid_o, bus.err_o, bus.mem_req_o}, 64'h6);
    @(posedge clk);
    #1;

    // Reset while waiting for read data; the late rvalid must be ignored.
    $display("[TB] reset mid-wait");
    rvDelay = 4;
    applyStimulus(LOAD, 32'h44, 32'h0, 1'b0, waitN);
    @(negedge clk);
    checkOutput("rw_in_req", bus.mem_req_o, 64'd1);
    @(negedge clk);
    checkOutput("rw_in_wait", {bus.busy_o, bus.mem_req_o}, 64'h2);
    @(posedge clk);
    #2;
    arstN = 1'b0;
    #1;
    checkOutput("rw_ready_now", bus.req_ready_o, 64'd1);
    checkOutput("rw_flags_now", {bus.busy_o, bus.mem_req_o, bus.rsp_valid_o, bus.err_o}, 64'd0);
    expQ.delete();
    base = rspCount;
    @(posedge clk);
    #2;
    arstN = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("rw_no_late_rsp", rspCount - base, 64'd0);
    checkOutput("rw_idle_ready", bus.req_ready_o, 64'd1);

    // Back-to-back store then load with req_valid held high.
    $display("[TB] back-to-back");
    rvDelay = 0;
    applyStimulus(STORE, 32'h200, 32'hCAFEF00D, 1'b1, waitN);
    checkOutput("b2b_first_wait", waitN, 64'd0);
    applyStimulus(LOAD, 32'h200, 32'h0, 1'b0, waitB);
    checkOutput("b2b_gap", waitB, 64'd2);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checkOutput("b2b_ld_rsp", bus.rsp_valid_o, (c == 3));
      if (c == 3) checkOutput("b2b_ld_rdata", bus.rdata_o, 64'hCAFEF00D);
    end
    @(posedge clk);
    #1;

    // Random loads/stores with 0-4 cycle grant and rvalid delays.
    $display("[TB] random traffic");
    base = rspCount;
    for (int i = 0; i < 5000; i++) begin
      gntDelay = int'($urandom_range(0, 4));
      rvDelay  = int'($urandom_range(0, 4));
      applyStimulus(($urandom_range(0, 1) == 1) ? STORE : LOAD,
                    32'($urandom_range(0, 31)) << 2, $urandom, 1'b0, waitN);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    waitN = 0;
    while (expQ.size() != 0 && waitN < 100) begin
      @(posedge clk);
      waitN++;
    end
    #1;
    checkOutput("rand_drain", expQ.size(), 64'd0);
    checkOutput("rand_rsp_count", rspCount - base, 64'd5000);

`ifdef DMEM_LSU_TIMEOUT_EN
    // Grant never arrives: error 16 cycles after entering REQ.
    $display("[TB] timeout expiry");
    @(posedge clk);
    #1;
    gntDelay = 1000;
    rvDelay  = 0;
    expectTimeout = 1'b1;
    applyStimulus(LOAD, 32'h10, 32'h0, 1'b0, waitN);
    expectTimeout = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      checkOutput("to_mem_req", bus.mem_req_o, (c <= 16));
      checkOutput("to_rsp_err", {bus.rsp_valid_o, bus.err_o}, (c == 17) ? 64'h3 : 64'h0);
    end
    @(posedge clk);
    #1;
    // Grant lands exactly on the expiry cycle and wins.
    gntDelay = 15;
    applyStimulus(STORE, 32'h14, 32'h55AA55AA, 1'b0, waitN);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      checkOutput("to_edge_mem_req", bus.mem_req_o, (c <= 16));
      checkOutput("to_edge_rsp_err", {bus.rsp_valid_o, bus.err_o}, (c == 17) ? 64'h2 : 64'h0);
    end
    @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit that sits directly downstream of the ALU memory stage.
- Takes one LOAD/STORE request per transaction: function, address and store data.
- Drives a request/grant/rvalid handshake to the data memory and returns load data plus a one-cycle response pulse.
- Raises busy so upstream holds its request stable while a memory access is in flight.

Parameters:
- DATA_WIDTH, 32, width of address, write data and read data (from simple_processor_pkg)
- TIMEOUT_CYCLES, 16, cycles spent in REQ+WAIT_RSP before abort (used only with the optional feature)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- arst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  upstream request valid
- req_ready_o  out  1  LSU can accept a request (high only in IDLE)
- func_i  in  func_t  LOAD or STORE (any other code is an error)
- addr_i  in  DATA_WIDTH  byte address
- wdata_i  in  DATA_WIDTH  store data
- rsp_valid_o  out  1  one-cycle completion pulse
- rdata_o  out  DATA_WIDTH  load data, valid with rsp_valid_o
- err_o  out  1  error flag, valid with rsp_valid_o
- busy_o  out  1  high in any state other than IDLE
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  DATA_WIDTH  word-aligned address
- mem_wdata_o  out  DATA_WIDTH  write data
- mem_gnt_i  in  1  memory accepted the request this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  DATA_WIDTH  read data

Behaviour:
- Reset (asynchronous, arst_ni=0):
  - state=IDLE; latched func/addr/wdata/rdata cleared to 0.
  - Outputs: req_ready_o=1, all other outputs 0.
  - Reset mid-transaction aborts it immediately; mem_req_o drops combinationally with the state change and no response is produced.
- State IDLE: req_ready_o=1.
  - Handshake fires when req_valid_i=1: latch func_i, addr_i, wdata_i.
  - Misaligned (addr_i[1:0]!=0) or func_i not LOAD/STORE -> ERR_RSP, no memory access.
  - Otherwise -> REQ.
- State REQ: mem_req_o=1.
  - mem_we_o=(func==STORE), mem_addr_o=latched addr, mem_wdata_o=latched wdata (0 for loads).
  - Request signals are held stable until mem_gnt_i=1.
  - On grant: STORE -> RESP; LOAD -> WAIT_RSP.
- State WAIT_RSP: mem_req_o=0.
  - On mem_rvalid_i=1: capture mem_rdata_i -> RESP.
  - mem_rvalid_i is ignored in every other state, including the grant cycle.
- State RESP: rsp_valid_o=1 for one cycle, err_o=0.
  - rdata_o = captured data for a LOAD, 0 for a STORE.
  - Next state IDLE.
- State ERR_RSP: rsp_valid_o=1, err_o=1, rdata_o=0 for one cycle; next state IDLE.
- Outside a response cycle, rdata_o and err_o are 0.
- Latency, with the request accepted in cycle 0:
  - Zero-wait store: grant in cycle 1, rsp_valid_o in cycle 2.
  - Zero-wait load: grant in cycle 1, rvalid in cycle 2, rsp_valid_o in cycle 3.
  - Error: rsp_valid_o in cycle 1.
- Throughput: req_ready_o=0 during RESP/ERR_RSP, so the next request is accepted one cycle after the response, at the earliest.
- Request inputs are sampled only at the accept handshake; changes afterwards have no effect.

Optional Feature:
- Macro: DMEM_LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT_RSP.
  - When the counter reaches TIMEOUT_CYCLES-1 with no grant/rvalid that cycle -> ERR_RSP, and mem_req_o drops.
  - A grant or rvalid arriving in the same cycle as expiry wins; no error is produced.
- Undefined: no counter; the LSU waits indefinitely; TIMEOUT_CYCLES is ignored.

Decomposition:
- simple_processor_pkg:
  - Already holds DATA_WIDTH and func_t (LOAD, STORE).
  - Add lsu_state_t (IDLE, REQ, WAIT_RSP, RESP, ERR_RSP) and DMEM_ADDR_ALIGN_BITS=2.
- One natural sub-module: dmem_lsu_timer (the timeout counter), instantiated only under DMEM_LSU_TIMEOUT_EN.
- FSM and datapath stay in dmem_lsu.

Test Plan:
- Zero-wait STORE: addr=0x100, wdata=0xDEADBEEF, gnt in the first REQ cycle -> mem_we_o=1 with that addr/data for one cycle; rsp_valid_o two cycles after accept, err_o=0, rdata_o=0.
- LOAD with waits: addr=0x40, gnt after 3 cycles, rvalid 2 cycles later with rdata=0x12345678 -> mem signals stable while waiting; rdata_o=0x12345678 with rsp_valid_o; busy_o high throughout.
- Misaligned LOAD: addr=0x41 -> no mem_req_o; rsp_valid_o+err_o one cycle after accept; rdata_o=0.
- Reset mid-WAIT_RSP: assert arst_ni=0 -> outputs 0 and req_ready_o=1 immediately; a late rvalid after reset produces no response.
- Back-to-back: STORE then LOAD, req_valid_i held high -> second accept occurs the cycle after the first rsp_valid_o; 5000 random LOAD/STORE transactions against a memory model with 0-4 cycle gnt/rvalid delays give zero data mismatches.
- Timeout (DMEM_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16): gnt never asserted -> ERR_RSP 16 cycles after entering REQ; a grant arriving exactly on the expiry cycle completes normally.
